// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   gnt_src_t   : which requester won the current grant
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths
package cpu_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_src_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the fetch port.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_inc       : fetch lost a contention this cycle
//   i_clr       : fetch was granted this cycle (takes priority over i_inc)
//   o_at_limit  : counter has reached LIMIT; fetch wins the next contention
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  logic [CNT_W-1:0] r_cnt;

  assign o_at_limit = (r_cnt == CNT_W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_at_limit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// the MEM-stage data port. Data wins contention unless fetch has lost
// STARVE_LIMIT times in a row. One transaction at a time; an IDLE cycle
// always follows a completion.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   if_req/if_addr             : fetch read request (held until if_ready)
//   if_rdata/if_ready          : fetch data, one-cycle completion pulse
//   dm_read/dm_write/dm_addr/dm_wdata : data request (held until dm_ready)
//   dm_rdata/dm_ready          : data read value, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : memory request (held until mem_ready)
//   mem_rdata/mem_ready        : memory read data and completion pulse
//   protocol_err               : sticky, dm_read and dm_write seen together
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = cpu_mem_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W       = cpu_mem_pkg::DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              protocol_err
);

  import cpu_mem_pkg::*;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_dropped;
  logic              r_protocol_err;

  logic              w_dm_any;
  logic              w_at_limit;
  logic              w_cnt_inc;
  logic              w_cnt_clr;
  logic              w_grant;
  gnt_src_t          w_gnt_src;
  logic              w_owner_req;

  assign w_dm_any = dm_read | dm_write;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .rst        (reset),
    .i_inc      (w_cnt_inc),
    .i_clr      (w_cnt_clr),
    .o_at_limit (w_at_limit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_src   = GNT_DM;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_owner_req = 1'b0;
    if_ready    = 1'b0;
    dm_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (if_req && (!w_dm_any || w_at_limit)) begin
          w_state_nxt = IF_BUSY;
          w_grant     = 1'b1;
          w_gnt_src   = GNT_IF;
          w_cnt_clr   = 1'b1;
        end else if (w_dm_any) begin
          w_state_nxt = DM_BUSY;
          w_grant     = 1'b1;
          w_gnt_src   = GNT_DM;
          // Only a contended DM grant counts as a fetch loss.
          w_cnt_inc   = if_req;
        end
      end
      IF_BUSY: begin
        w_owner_req = if_req;
        if (mem_ready) begin
          w_state_nxt = IDLE;
          if_ready    = if_req && !r_dropped;
        end
      end
      DM_BUSY: begin
        w_owner_req = w_dm_any;
        if (mem_ready) begin
          w_state_nxt = IDLE;
          dm_ready    = w_dm_any && !r_dropped;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_dropped      <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_dropped <= 1'b0;
        if (w_gnt_src == GNT_DM) begin
          r_mem_we    <= dm_write;
          r_mem_addr  <= dm_addr;
          r_mem_wdata <= dm_wdata;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= if_addr;
          r_mem_wdata <= '0;
        end
      end else if (r_state != IDLE && !w_owner_req) begin
        // Once the owner lets go, the transaction is orphaned even if the
        // request is raised again before mem_ready; its data is discarded.
        r_dropped <= 1'b1;
      end
      if (dm_read && dm_write) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  assign mem_req      = (r_state != IDLE);
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign protocol_err = r_protocol_err;

  assign if_rdata = if_ready ? mem_rdata : '0;
  assign dm_rdata = (dm_ready && !r_mem_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int TIMEOUT = 200;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          protocol_err;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_ready     (if_ready),
    .dm_read      (dm_read),
    .dm_write     (dm_write),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_ready     (dm_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];

  int force_wait = 0;
  bit stray_en   = 0;
  bit mon_en     = 0;

  // Memory contents as a pure function of the address.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: fixed or random wait states, optional stray pulses in idle.
  initial begin : responder
    int wcnt;
    wcnt      = -1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (reset) begin
        wcnt = -1;
      end else if (mem_req) begin
        if (wcnt < 0) wcnt = (force_wait < 0) ? int'($urandom_range(0, 3)) : force_wait;
        if (wcnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_we ? $urandom : memf(mem_addr);
          wcnt      = -1;
        end else begin
          wcnt--;
        end
      end else if (stray_en && ($urandom_range(0, 5) == 0)) begin
        mem_ready = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Transaction-level reference: which port owns the memory, what it asked for,
  // how many contentions fetch has lost, and whether the owner walked away.
  bit            m_busy, m_owner_dm, m_dropped, m_perr, m_we;
  int            m_losses;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            p_if, p_rd, p_wr, p_mr;
  logic [AW-1:0] p_ia, p_da;
  logic [DW-1:0] p_wd;

  function automatic void model_reset();
    m_busy = 0; m_owner_dm = 0; m_dropped = 0; m_perr = 0; m_we = 0;
    m_losses = 0; m_addr = '0; m_wdata = '0;
    p_if = 0; p_rd = 0; p_wr = 0; p_mr = 0; p_ia = '0; p_da = '0; p_wd = '0;
  endfunction

  initial begin : monitor
    bit p_dm, p_owner, exp_ifr, exp_dmr;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        // Apply the clock edge that separated the previous sample from this one.
        p_dm = p_rd | p_wr;
        if (!m_busy) begin
          if (p_if || p_dm) begin
            m_busy    = 1;
            m_dropped = 0;
            if (p_if && (!p_dm || m_losses >= int'(SL))) begin
              m_owner_dm = 0; m_losses = 0;
              m_addr = p_ia; m_we = 0; m_wdata = '0;
            end else begin
              if (p_if) m_losses++;
              m_owner_dm = 1;
              m_addr = p_da; m_we = p_wr; m_wdata = p_wd;
            end
          end
        end else begin
          p_owner = m_owner_dm ? p_dm : p_if;
          if (!p_owner) m_dropped = 1;
          if (p_mr) m_busy = 0;
        end
        if (p_rd && p_wr) m_perr = 1;

        chk1("mem_req", mem_req, m_busy);
        if (m_busy) begin
          chkw("mem_addr", mem_addr, m_addr);
          chk1("mem_we", mem_we, m_we);
          if (m_we) chkw("mem_wdata", mem_wdata, m_wdata);
        end
        exp_ifr = m_busy && !m_owner_dm && mem_ready && if_req && !m_dropped;
        exp_dmr = m_busy && m_owner_dm && mem_ready && (dm_read || dm_write) && !m_dropped;
        chk1("if_ready", if_ready, exp_ifr);
        chk1("dm_ready", dm_ready, exp_dmr);
        chk1("protocol_err", protocol_err, m_perr);

        if (if_ready) begin
          if (if_q.size() == 0) chk1("if_ready_unexpected", if_ready, 1'b0);
          else chkw("if_rdata", if_rdata, if_q.pop_front());
        end else begin
          chkw("if_rdata_idle", if_rdata, '0);
        end
        if (dm_ready) begin
          if (dm_q.size() == 0) chk1("dm_ready_unexpected", dm_ready, 1'b0);
          else chkw("dm_rdata", dm_rdata, dm_q.pop_front());
        end else begin
          chkw("dm_rdata_idle", dm_rdata, '0);
        end

        p_if = if_req; p_rd = dm_read; p_wr = dm_write; p_mr = mem_ready;
        p_ia = if_addr; p_da = dm_addr; p_wd = dm_wdata;
      end
    end
  end

  // Fetch requester: hold until if_ready, or abandon after drop_at cycles (0 = never).
  task automatic fetch_req(input logic [AW-1:0] a, input int drop_at);
    int cyc;
    bit done;
    cyc = 0; done = 0;
    if_addr = a; if_req = 1'b1;
    if_q.push_back(memf(a));
    while (!done) begin
      @(negedge clk);
      if (if_ready) begin
        done = 1;
      end else begin
        cyc++;
        if ((drop_at > 0 && cyc >= drop_at) || cyc > TIMEOUT) begin
          if (cyc > TIMEOUT) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_timeout: actual=no if_ready required=if_ready within %0d cycles t=%0t", TIMEOUT, $time);
          end
          void'(if_q.pop_back());
          done = 1;
          @(posedge clk); #1;
          if_req = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int drop_at);
    int cyc;
    bit done;
    cyc = 0; done = 0;
    dm_addr = a; dm_wdata = wd; dm_read = rd; dm_write = wr;
    dm_q.push_back(wr ? '0 : memf(a));
    while (!done) begin
      @(negedge clk);
      if (dm_ready) begin
        done = 1;
      end else begin
        cyc++;
        if ((drop_at > 0 && cyc >= drop_at) || cyc > TIMEOUT) begin
          if (cyc > TIMEOUT) begin
            n_checks++; n_fail++;
            $display("FAIL dm_timeout: actual=no dm_ready required=dm_ready within %0d cycles t=%0t", TIMEOUT, $time);
          end
          void'(dm_q.pop_back());
          done = 1;
          @(posedge clk); #1;
          dm_read = 1'b0; dm_write = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    dm_read = 1'b0; dm_write = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=still running required=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int gap, drop, kind;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chkw("rst_mem_addr", mem_addr, '0);
    chkw("rst_mem_wdata", mem_wdata, '0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_dm_ready", dm_ready, 1'b0);
    chkw("rst_if_rdata", if_rdata, '0);
    chkw("rst_dm_rdata", dm_rdata, '0);
    chk1("rst_protocol_err", protocol_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1;

    // Single fetch, zero-wait memory
    force_wait = 0;
    fetch_req(32'h40, 0);
    repeat (2) @(posedge clk); #1;

    // Data write with three wait states
    force_wait = 3;
    dm_req(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 0);
    dm_req(1'b1, 1'b0, 32'h104, 32'h0, 0);

    // Continuous contention with a zero-wait memory
    force_wait = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) fetch_req(32'h1000 + 32'(4 * i), 0);
      end
      begin
        for (int i = 0; i < 16; i++) dm_req(i[0], !i[0], 32'h2000 + 32'(4 * i), 32'(i) * 32'h0101_0101, 0);
      end
    join
    repeat (2) @(posedge clk); #1;

    // Abandoned fetch with two wait states, then a normal fetch
    force_wait = 2;
    fetch_req(32'h80, 2);
    fetch_req(32'h84, 0);

    // Both dm_read and dm_write high
    dm_req(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 0);
    repeat (3) @(posedge clk); #1;
    chk1("protocol_err_sticky", protocol_err, 1'b1);

    // Randomized traffic with random wait states and stray mem_ready pulses
    force_wait = -1;
    stray_en = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          gap  = $urandom_range(0, 3);
          drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
          fetch_req($urandom & 32'hFFFF_FFFC, drop);
          if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        end
      end
      begin : dm_rand
        int dgap, ddrop;
        for (int i = 0; i < 40; i++) begin
          dgap  = $urandom_range(0, 3);
          ddrop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
          kind  = $urandom_range(0, 9);
          dm_req(kind < 5 || kind == 9, kind >= 5, $urandom & 32'hFFFF_FFFC, $urandom, ddrop);
          if (dgap > 0) begin repeat (dgap) @(posedge clk); #1; end
        end
      end
    join
    stray_en = 0;
    repeat (4) @(posedge clk); #1;

    // Reset asserted mid-wait in DM_BUSY
    mon_en = 0;
    force_wait = 8;
    dm_addr = 32'h300; dm_wdata = 32'h1234_5678; dm_write = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk1("pre_rst_mem_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk1("async_rst_mem_req", mem_req, 1'b0);
    chk1("async_rst_dm_ready", dm_ready, 1'b0);
    chk1("async_rst_mem_we", mem_we, 1'b0);
    chk1("async_rst_protocol_err", protocol_err, 1'b0);
    chk1("async_rst_starve_at_limit", dut.u_starve_ctr.o_at_limit, 1'b0);
    dm_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    if_q.delete();
    dm_q.delete();
    model_reset();
    mon_en = 1;

    // Fresh fetch after reset, then a short contention burst
    force_wait = 0;
    fetch_req(32'h44, 0);
    fork
      begin
        for (int i = 0; i < 2; i++) fetch_req(32'h500 + 32'(4 * i), 0);
      end
      begin
        for (int i = 0; i < 7; i++) dm_req(1'b1, 1'b0, 32'h600 + 32'(4 * i), '0, 0);
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 0;
    chkw("if_q_drained", 32'(if_q.size()), '0);
    chkw("dm_q_drained", 32'(dm_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
